// File: rtl/frame_count_gen_pkg.sv
// isp_video_pkg: shared definitions for the ISP output-stage frame counter.
// Contents:
//   fsm_state_t    - frame tracker states (IDLE / SYNC / FRAME)
//   DEF_CNT_W      - default width of the running frame count
//   DEF_LINE_W     - default width of the per-frame line count
//   VS_POL_HIGH/LOW- vsync polarity selectors
//   ERR_CNT_W      - width of the saturating error-frame count
package isp_video_pkg;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_SYNC  = 2'd1,
    ST_FRAME = 2'd2
  } fsm_state_t;

  localparam int DEF_CNT_W  = 16;
  localparam int DEF_LINE_W = 12;
  localparam int ERR_CNT_W  = 8;

  localparam bit VS_POL_HIGH = 1'b1;
  localparam bit VS_POL_LOW  = 1'b0;

endpackage

// File: rtl/frame_count_gen_edge_det.sv
// sig_edge_det: registers a level signal once and reports its edges.
// Ports:
//   ispclk - clock
//   rst_n  - async active-low reset (all registers clear to 0)
//   d      - level input, synchronous to ispclk
//   q      - d delayed by one clock
//   rise   - 1 for one cycle after q goes 0->1
//   fall   - 1 for one cycle after q goes 1->0
module sig_edge_det (
  input  logic ispclk,
  input  logic rst_n,
  input  logic d,
  output logic q,
  output logic rise,
  output logic fall
);

  logic q_dly;

  always_ff @(posedge ispclk or negedge rst_n) begin
    if (!rst_n) begin
      q     <= 1'b0;
      q_dly <= 1'b0;
    end else begin
      q     <= d;
      q_dly <= q;
    end
  end

  assign rise = q & ~q_dly;
  assign fall = ~q & q_dly;

endmodule

// File: rtl/frame_count_gen.sv
// frame_count_gen: counts completed video frames at the ISP output stage for
// the FPS display. Runs beside the pixel datapath and never stalls it.
// Optional build macro: FRAME_CHECK_EN adds per-frame geometry checking
// (lines per frame, valid pixels per line); without it frame_err and err_cnt
// are tied to 0.
// Ports:
//   ispclk, rst_n     - pixel clock, async active-low reset
//   enable            - 1 counts; 0 returns to IDLE with counts held
//   clear             - sync clear of frames_cnt and err_cnt (wins over increment)
//   vsync_i, href_i   - video timing (vsync polarity set by VS_ACTIVE_HIGH)
//   pix_vld_i         - pixel valid, used only by the geometry check
//   frames_cnt        - completed-frame count, wraps
//   frame_done        - one-cycle pulse per counted frame
//   line_cnt          - lines seen so far in the current frame (saturating)
//   frame_act         - 1 while the tracker is in FRAME
//   frame_err         - one-cycle pulse with frame_done for a bad-geometry frame
//   err_cnt           - saturating count of bad-geometry frames
module frame_count_gen
  import isp_video_pkg::*;
#(
  parameter bit VS_ACTIVE_HIGH = VS_POL_HIGH,
  parameter int CNT_W          = DEF_CNT_W,
  parameter int LINE_W         = DEF_LINE_W,
  parameter int PIX_W          = 12,
  parameter int EXP_LINES      = 720,
  parameter int EXP_PIX        = 1280
) (
  input  logic                 ispclk,
  input  logic                 rst_n,
  input  logic                 enable,
  input  logic                 clear,
  input  logic                 vsync_i,
  input  logic                 href_i,
  input  logic                 pix_vld_i,
  output logic [CNT_W-1:0]     frames_cnt,
  output logic                 frame_done,
  output logic [LINE_W-1:0]    line_cnt,
  output logic                 frame_act,
  output logic                 frame_err,
  output logic [ERR_CNT_W-1:0] err_cnt
);

  fsm_state_t        state_q;
  fsm_state_t        state_d;
  logic              vs_norm;
  logic              vs_edge;
  logic              line_end;
  logic              in_frame;
  logic              frame_close;
  logic [LINE_W-1:0] line_inc;
  logic [LINE_W-1:0] lines_eff;
  logic              unused_vs_lvl;
  logic              unused_vs_fall;
  logic              unused_href_lvl;
  logic              unused_href_rise;

  // Normalise vsync so the edge detector always looks for an asserting edge.
  assign vs_norm = VS_ACTIVE_HIGH ? vsync_i : ~vsync_i;

  sig_edge_det u_vs_det (
    .ispclk (ispclk),
    .rst_n  (rst_n),
    .d      (vs_norm),
    .q      (unused_vs_lvl),
    .rise   (vs_edge),
    .fall   (unused_vs_fall)
  );

  sig_edge_det u_href_det (
    .ispclk (ispclk),
    .rst_n  (rst_n),
    .d      (href_i),
    .q      (unused_href_lvl),
    .rise   (unused_href_rise),
    .fall   (line_end)
  );

  // A line ending in the same cycle as the closing vsync still belongs to the
  // closing frame, so frame decisions use lines_eff rather than line_cnt.
  assign line_inc  = (&line_cnt) ? line_cnt : line_cnt + 1'b1;
  assign lines_eff = line_end ? line_inc : line_cnt;
  assign in_frame  = enable && (state_q == ST_FRAME);
  assign frame_act = (state_q == ST_FRAME);

  always_comb begin
    state_d     = state_q;
    frame_close = 1'b0;
    if (!enable) begin
      state_d = ST_IDLE;
    end else begin
      case (state_q)
        ST_IDLE:  state_d = ST_SYNC;
        ST_SYNC:  if (vs_edge) state_d = ST_FRAME;
        ST_FRAME: if (vs_edge && (lines_eff != '0)) frame_close = 1'b1;
        default:  state_d = ST_IDLE;
      endcase
    end
  end

  always_ff @(posedge ispclk or negedge rst_n) begin
    if (!rst_n) begin
      state_q    <= ST_IDLE;
      line_cnt   <= '0;
      frames_cnt <= '0;
      frame_done <= 1'b0;
    end else begin
      state_q    <= state_d;
      frame_done <= 1'b0;
      if (!in_frame || vs_edge) begin
        line_cnt <= '0;
      end else if (line_end) begin
        line_cnt <= line_inc;
      end
      if (clear) begin
        frames_cnt <= '0;
      end else if (frame_close) begin
        frames_cnt <= frames_cnt + 1'b1;
        frame_done <= 1'b1;
      end
    end
  end

`ifdef FRAME_CHECK_EN
  logic             pix_q;
  logic [PIX_W-1:0] pix_cnt;
  logic             bad_q;
  logic             line_bad;
  logic             frame_bad;

  // pix_q lines up with the registered href, so by the line_end cycle every
  // pixel of the line is already in pix_cnt.
  assign line_bad  = line_end && (pix_cnt != PIX_W'(EXP_PIX));
  assign frame_bad = bad_q || line_bad || (lines_eff != LINE_W'(EXP_LINES));

  always_ff @(posedge ispclk or negedge rst_n) begin
    if (!rst_n) begin
      pix_q     <= 1'b0;
      pix_cnt   <= '0;
      bad_q     <= 1'b0;
      frame_err <= 1'b0;
      err_cnt   <= '0;
    end else begin
      pix_q     <= pix_vld_i;
      frame_err <= 1'b0;
      if (!in_frame) begin
        pix_cnt <= '0;
      end else if (line_end) begin
        pix_cnt <= {{(PIX_W-1){1'b0}}, pix_q};
      end else if (pix_q && !(&pix_cnt)) begin
        pix_cnt <= pix_cnt + 1'b1;
      end
      if (!in_frame || vs_edge) begin
        bad_q <= 1'b0;
      end else if (line_bad) begin
        bad_q <= 1'b1;
      end
      if (clear) begin
        err_cnt <= '0;
      end else if (frame_close && frame_bad) begin
        frame_err <= 1'b1;
        if (!(&err_cnt)) err_cnt <= err_cnt + 1'b1;
      end
    end
  end
`else
  logic unused_check_cfg;

  assign frame_err        = 1'b0;
  assign err_cnt          = '0;
  assign unused_check_cfg = ^{pix_vld_i, PIX_W[0], EXP_LINES[0], EXP_PIX[0]};
`endif

endmodule

// File: tb/tb_frame_count_gen.sv
// tb_frame_count_gen: self-checking bench for frame_count_gen.
// A behavioural model tracks the registered inputs and frame rules every
// cycle; directed vector rows and hand sequences add fixed expectations.
module tb_frame_count_gen;

  localparam int LINE_W    = 12;
  localparam int EXP_LINES = 4;
  localparam int EXP_PIX   = 8;
`ifdef FRAME_CHECK_EN
  localparam bit CHK = 1'b1;
`else
  localparam bit CHK = 1'b0;
`endif
  localparam int M_IDLE  = 0;
  localparam int M_SYNC  = 1;
  localparam int M_FRAME = 2;

  logic              ispclk    = 1'b0;
  logic              rst_n     = 1'b0;
  logic              enable    = 1'b0;
  logic              clear     = 1'b0;
  logic              vsync_i   = 1'b0;
  logic              href_i    = 1'b0;
  logic              pix_vld_i = 1'b0;
  logic [15:0]       frames_cnt;
  logic              frame_done;
  logic [LINE_W-1:0] line_cnt;
  logic              frame_act;
  logic              frame_err;
  logic [7:0]        err_cnt;

  always #5 ispclk = ~ispclk;

  frame_count_gen #(
    .EXP_LINES (EXP_LINES),
    .EXP_PIX   (EXP_PIX)
  ) dut (
    .ispclk     (ispclk),
    .rst_n      (rst_n),
    .enable     (enable),
    .clear      (clear),
    .vsync_i    (vsync_i),
    .href_i     (href_i),
    .pix_vld_i  (pix_vld_i),
    .frames_cnt (frames_cnt),
    .frame_done (frame_done),
    .line_cnt   (line_cnt),
    .frame_act  (frame_act),
    .frame_err  (frame_err),
    .err_cnt    (err_cnt)
  );

  int errors = 0;
  int checks = 0;

  // Reference model state: mode, counts, and the last two sampled inputs.
  int m_mode, m_frames, m_errs, m_lines, m_pix;
  bit m_bad, m_done, m_err;
  bit h_vs1, h_vs2, h_hr1, h_hr2, h_pv1;

  function automatic void model_reset();
    m_mode = M_IDLE; m_frames = 0; m_errs = 0; m_lines = 0; m_pix = 0;
    m_bad = 0; m_done = 0; m_err = 0;
    h_vs1 = 0; h_vs2 = 0; h_hr1 = 0; h_hr2 = 0; h_pv1 = 0;
  endfunction

  // Advance the model by one clock edge using the inputs presented now.
  function automatic void model_step();
    bit vs_e, ln_e, bad_now;
    int lines_now;
    vs_e   = h_vs1 && !h_vs2;
    ln_e   = !h_hr1 && h_hr2;
    m_done = 0;
    m_err  = 0;
    if (!enable) begin
      m_mode = M_IDLE; m_lines = 0; m_pix = 0; m_bad = 0;
    end else if (m_mode == M_IDLE) begin
      m_mode = M_SYNC;
    end else if (m_mode == M_SYNC) begin
      if (vs_e) m_mode = M_FRAME;
      m_pix = 0; m_bad = 0;
    end else begin
      lines_now = m_lines;
      bad_now   = m_bad;
      if (ln_e) begin
        lines_now = (m_lines < 4095) ? m_lines + 1 : 4095;
        if (m_pix != EXP_PIX) bad_now = 1;
      end
      if (vs_e) begin
        if (lines_now != 0 && !clear) begin
          m_frames = (m_frames + 1) % 65536;
          m_done   = 1;
          if (bad_now || lines_now != EXP_LINES) begin
            m_err = 1;
            if (m_errs < 255) m_errs++;
          end
        end
        m_lines = 0; m_bad = 0;
      end else begin
        m_lines = lines_now; m_bad = bad_now;
      end
      if (ln_e) m_pix = h_pv1 ? 1 : 0;
      else if (h_pv1 && m_pix < 4095) m_pix++;
    end
    if (clear) begin
      m_frames = 0; m_errs = 0;
    end
    h_vs2 = h_vs1; h_vs1 = vsync_i;
    h_hr2 = h_hr1; h_hr1 = href_i;
    h_pv1 = pix_vld_i;
  endfunction

  task automatic check_output(input string name, input int act, input int exp);
    checks++;
    if (act != exp) begin
      errors++;
      $display("[TB] FAIL %s: got %0d expected %0d (t=%0t)", name, act, exp, $time);
    end
  endtask

  // One clock: step the model, let the edge pass, compare every output.
  task automatic tick();
    model_step();
    @(posedge ispclk);
    #1;
    check_output("model_frames_cnt", 32'(frames_cnt), m_frames);
    check_output("model_frame_done", 32'(frame_done), 32'(m_done));
    check_output("model_line_cnt", 32'(line_cnt), m_lines);
    check_output("model_frame_act", 32'(frame_act), (m_mode == M_FRAME) ? 1 : 0);
    check_output("model_frame_err", 32'(frame_err), CHK ? 32'(m_err) : 0);
    check_output("model_err_cnt", 32'(err_cnt), CHK ? m_errs : 0);
  endtask

  task automatic check_reset_vals(input string tag);
    check_output({tag, "_frames_cnt"}, 32'(frames_cnt), 0);
    check_output({tag, "_frame_done"}, 32'(frame_done), 0);
    check_output({tag, "_line_cnt"}, 32'(line_cnt), 0);
    check_output({tag, "_frame_act"}, 32'(frame_act), 0);
    check_output({tag, "_frame_err"}, 32'(frame_err), 0);
    check_output({tag, "_err_cnt"}, 32'(err_cnt), 0);
  endtask

  // Pulse vsync and capture outputs in the cycle where a count must appear.
  task automatic apply_stimulus_vsync(input bit clr_at_done, output int cnt,
                                      output bit done, output bit err);
    vsync_i = 1'b1;
    tick();
    check_output("done_before_latency", 32'(frame_done), 0);
    vsync_i = 1'b0;
    clear   = clr_at_done;
    tick();
    cnt   = 32'(frames_cnt);
    done  = frame_done;
    err   = frame_err;
    clear = 1'b0;
    tick();
    check_output("done_pulse_width", 32'(frame_done), 0);
  endtask

  task automatic apply_stimulus_line(input int npix);
    int len;
    len    = (npix > 8) ? npix : 8;
    href_i = 1'b1;
    for (int i = 0; i < len; i++) begin
      pix_vld_i = (i < npix);
      tick();
    end
    href_i    = 1'b0;
    pix_vld_i = 1'b0;
    tick();
    tick();
  endtask

  typedef struct {
    int lines;
    int pix;
    int exp_cnt;
    bit exp_done;
    bit exp_err;
    int exp_errc;
  } frame_vec_t;

  frame_vec_t vecs[8];

  initial begin
    int cnt;
    bit dn, er;

    // Each row: vsync (closing the previous row's frame), then its lines.
    vecs[0] = '{4, 8, 0, 1'b0, 1'b0, 0};
    vecs[1] = '{4, 8, 1, 1'b1, 1'b0, 0};
    vecs[2] = '{4, 8, 2, 1'b1, 1'b0, 0};
    vecs[3] = '{0, 8, 3, 1'b1, 1'b0, 0};
    vecs[4] = '{4, 7, 3, 1'b0, 1'b0, 0};
    vecs[5] = '{3, 8, 4, 1'b1, 1'b1, 1};
    vecs[6] = '{4, 8, 5, 1'b1, 1'b1, 2};
    vecs[7] = '{0, 8, 6, 1'b1, 1'b0, 2};

    model_reset();
    #12;
    check_reset_vals("reset");
    rst_n  = 1'b1;
    #1;
    enable = 1'b1;
    repeat (3) tick();

    for (int i = 0; i < 8; i++) begin
      apply_stimulus_vsync(1'b0, cnt, dn, er);
      check_output($sformatf("vec%0d_frames_cnt", i), cnt, vecs[i].exp_cnt);
      check_output($sformatf("vec%0d_frame_done", i), 32'(dn), 32'(vecs[i].exp_done));
      check_output($sformatf("vec%0d_frame_err", i), 32'(er), CHK ? 32'(vecs[i].exp_err) : 0);
      check_output($sformatf("vec%0d_err_cnt", i), 32'(err_cnt), CHK ? vecs[i].exp_errc : 0);
      check_output($sformatf("vec%0d_frame_act", i), 32'(frame_act), 1);
      for (int l = 0; l < vecs[i].lines; l++) apply_stimulus_line(vecs[i].pix);
      check_output($sformatf("vec%0d_line_cnt", i), 32'(line_cnt), vecs[i].lines);
    end

    // Wrap: preload the counter one below rollover.
    force dut.frames_cnt = 16'hFFFF;
    #1;
    release dut.frames_cnt;
    m_frames = 65535;
    apply_stimulus_line(8);
    apply_stimulus_vsync(1'b0, cnt, dn, er);
    check_output("wrap_frames_cnt", cnt, 0);
    check_output("wrap_frame_done", 32'(dn), 1);

    // Clear in the frame_done cycle beats the increment.
    apply_stimulus_line(8);
    apply_stimulus_vsync(1'b1, cnt, dn, er);
    check_output("clear_frames_cnt", cnt, 0);
    check_output("clear_frame_done", 32'(dn), 0);
    check_output("clear_err_cnt", 32'(err_cnt), 0);
    repeat (4) apply_stimulus_line(8);
    apply_stimulus_vsync(1'b0, cnt, dn, er);
    check_output("after_clear_frames_cnt", cnt, 1);
    check_output("after_clear_frame_done", 32'(dn), 1);

    // Enable dropped mid-frame: back to IDLE, counts held, SYNC needed again.
    repeat (2) apply_stimulus_line(8);
    check_output("drop_line_cnt_before", 32'(line_cnt), 2);
    enable = 1'b0;
    tick();
    check_output("drop_frame_act", 32'(frame_act), 0);
    check_output("drop_line_cnt", 32'(line_cnt), 0);
    check_output("drop_frames_cnt", 32'(frames_cnt), 1);
    enable = 1'b1;
    repeat (2) tick();
    apply_stimulus_line(8);
    check_output("sync_line_cnt", 32'(line_cnt), 0);
    apply_stimulus_vsync(1'b0, cnt, dn, er);
    check_output("resync_frames_cnt", cnt, 1);
    check_output("resync_frame_done", 32'(dn), 0);
    apply_stimulus_line(8);
    apply_stimulus_vsync(1'b0, cnt, dn, er);
    check_output("resync_count_frames_cnt", cnt, 2);

    // Async reset in the middle of a line.
    href_i = 1'b1;
    pix_vld_i = 1'b1;
    repeat (3) tick();
    #2;
    rst_n = 1'b0;
    #1;
    check_reset_vals("async_reset");
    model_reset();
    href_i = 1'b0;
    pix_vld_i = 1'b0;
    #1;
    rst_n = 1'b1;
    repeat (3) tick();
    apply_stimulus_line(8);
    apply_stimulus_vsync(1'b0, cnt, dn, er);
    check_output("post_reset_sync_frames_cnt", cnt, 0);
    apply_stimulus_line(8);
    apply_stimulus_vsync(1'b0, cnt, dn, er);
    check_output("post_reset_count_frames_cnt", cnt, 1);

    // Randomised frames, with occasional enable drops and clears.
    for (int f = 0; f < 40; f++) begin
      if ($urandom_range(0, 9) == 0) begin
        enable = 1'b0;
        repeat ($urandom_range(1, 3)) tick();
        enable = 1'b1;
      end
      vsync_i = 1'b1;
      tick();
      vsync_i = 1'b0;
      clear   = ($urandom_range(0, 7) == 0);
      tick();
      clear   = 1'b0;
      repeat ($urandom_range(0, 4)) apply_stimulus_line($urandom_range(6, 9));
    end

    // Unstructured random timing.
    for (int c = 0; c < 1500; c++) begin
      enable    = ($urandom_range(0, 15) != 0);
      clear     = ($urandom_range(0, 31) == 0);
      vsync_i   = ($urandom_range(0, 7) == 0);
      href_i    = ($urandom_range(0, 3) != 0);
      pix_vld_i = $urandom_range(0, 1) != 0;
      tick();
    end

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
